// File: rtl/noc_pkg.sv
// Shared NoC flit definitions for the scheduler/PE packet protocol.
// Field offsets, default geometry and flit pack/unpack helpers.
package noc_pkg;

   localparam int DATA_W    = 32;
   localparam int X_W       = 2;
   localparam int Y_W       = 2;
   localparam int PCK_W     = 4;
   localparam int TAG_DEPTH = 4;
   localparam int TOTAL_W   = DATA_W + PCK_W + Y_W + X_W;

   localparam int X_LSB    = 0;
   localparam int X_MSB    = X_W - 1;
   localparam int Y_LSB    = X_W;
   localparam int Y_MSB    = X_W + Y_W - 1;
   localparam int PCK_LSB  = X_W + Y_W;
   localparam int PCK_MSB  = X_W + Y_W + PCK_W - 1;
   localparam int DATA_LSB = X_W + Y_W + PCK_W;
   localparam int DATA_MSB = TOTAL_W - 1;

   localparam int MY_X  = 0;
   localparam int MY_Y  = 1;
   localparam int SCH_X = 0;
   localparam int SCH_Y = 0;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PCK_W-1:0]  pck_no;
      logic [Y_W-1:0]    y;
      logic [X_W-1:0]    x;
   } flit_t;

   function automatic logic [TOTAL_W-1:0] flit_pack(input flit_t f);
      return {f.data, f.pck_no, f.y, f.x};
   endfunction

   function automatic flit_t flit_unpack(input logic [TOTAL_W-1:0] v);
      flit_t f;
      f.x      = v[X_MSB:X_LSB];
      f.y      = v[Y_MSB:Y_LSB];
      f.pck_no = v[PCK_MSB:PCK_LSB];
      f.data   = v[DATA_MSB:DATA_LSB];
      return f;
   endfunction

endpackage

// File: rtl/pe_noc_interface_tag_fifo.sv
// Outstanding request-tag FIFO for pe_noc_interface.
// Synchronous, power-of-two depth, with full/empty/count status.
module tag_fifo
   import noc_pkg::*;
#(
   parameter int W     = noc_pkg::PCK_W,
   parameter int DEPTH = noc_pkg::TAG_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [W-1:0]             din_i,
   input  logic                     pop_i,
   output logic [W-1:0]             dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; the count alone defines validity.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/pe_noc_interface.sv
// Responder-side NoC interface: strips request flits for the PE and
// re-tags PE results for the scheduler. Option: PE_ADDR_CHECK_EN.
module pe_noc_interface
   import noc_pkg::*;
#(
   parameter int DATA_W    = noc_pkg::DATA_W,
   parameter int X_W       = noc_pkg::X_W,
   parameter int Y_W       = noc_pkg::Y_W,
   parameter int PCK_W     = noc_pkg::PCK_W,
   parameter int TAG_DEPTH = noc_pkg::TAG_DEPTH,
   parameter int MY_X      = noc_pkg::MY_X,
   parameter int MY_Y      = noc_pkg::MY_Y,
   parameter int SCH_X     = noc_pkg::SCH_X,
   parameter int SCH_Y     = noc_pkg::SCH_Y,
   parameter int TOTAL_W   = DATA_W + PCK_W + Y_W + X_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_valid,
   input  logic [TOTAL_W-1:0] i_data,
   output logic               o_ready,
   output logic               o_valid,
   output logic [TOTAL_W-1:0] o_data,
   input  logic               i_ready,
   output logic               o_valid_pe,
   output logic [DATA_W-1:0]  o_data_pe,
   input  logic               i_ready_pe,
   input  logic               i_valid_pe,
   input  logic [DATA_W-1:0]  i_data_pe,
   output logic               o_ready_pe
`ifdef PE_ADDR_CHECK_EN
  ,output logic [7:0]         o_drop_cnt
`endif
);

   localparam int F_X   = 0;
   localparam int F_Y   = X_W;
   localparam int F_PCK = X_W + Y_W;
   localparam int F_DAT = X_W + Y_W + PCK_W;
   localparam int CW    = $clog2(TAG_DEPTH) + 1;

   logic [X_W-1:0]    hdr_x;
   logic [Y_W-1:0]    hdr_y;
   logic [PCK_W-1:0]  hdr_pck;
   logic [DATA_W-1:0] hdr_dat;

   logic              req_vld_q, req_vld_d;
   logic [DATA_W-1:0] req_q, req_d;
   logic              out_vld_q, out_vld_d;
   logic [TOTAL_W-1:0] out_q, out_d;

   logic              in_fire, addr_ok, push;
   logic              pe_fire, res_fire, eg_fire;
   logic [PCK_W-1:0]  tag_head;
   logic              tag_full, tag_empty;
   logic [CW-1:0]     tag_cnt;

   assign hdr_x   = i_data[F_X   +: X_W];
   assign hdr_y   = i_data[F_Y   +: Y_W];
   assign hdr_pck = i_data[F_PCK +: PCK_W];
   assign hdr_dat = i_data[F_DAT +: DATA_W];

`ifdef PE_ADDR_CHECK_EN
   logic [7:0] drop_q, drop_d;
   logic       unused_sig;

   assign addr_ok = (hdr_x == X_W'(MY_X)) &&
                    (hdr_y == Y_W'(MY_Y));
   assign unused_sig = ^tag_cnt;
`else
   logic unused_sig;

   assign addr_ok    = 1'b1;
   assign unused_sig = ^{hdr_x, hdr_y, tag_cnt};
`endif

   assign o_ready    = !req_vld_q && !tag_full;
   assign o_ready_pe = !tag_empty && (!out_vld_q || i_ready);

   assign in_fire  = i_valid && o_ready;
   assign push     = in_fire && addr_ok;
   assign pe_fire  = req_vld_q && i_ready_pe;
   assign res_fire = i_valid_pe && o_ready_pe;
   assign eg_fire  = out_vld_q && i_ready;

   tag_fifo #(
      .W     (PCK_W),
      .DEPTH (TAG_DEPTH)
   ) u_tags (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .din_i   (hdr_pck),
      .pop_i   (res_fire),
      .dout_o  (tag_head),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .count_o (tag_cnt)
   );

   always_comb begin
      req_vld_d = req_vld_q;
      req_d     = req_q;
      if (pe_fire) begin
         req_vld_d = 1'b0;
      end
      if (push) begin
         req_vld_d = 1'b1;
         req_d     = hdr_dat;
      end
   end

   // A load in the same cycle as a drain keeps o_valid high.
   always_comb begin
      out_vld_d = out_vld_q;
      out_d     = out_q;
      if (eg_fire) begin
         out_vld_d = 1'b0;
      end
      if (res_fire) begin
         out_vld_d = 1'b1;
         out_d     = {i_data_pe, tag_head,
                      Y_W'(SCH_Y), X_W'(SCH_X)};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_vld_q <= 1'b0;
         req_q     <= '0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else begin
         req_vld_q <= req_vld_d;
         req_q     <= req_d;
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
      end
   end

`ifdef PE_ADDR_CHECK_EN
   always_comb begin
      drop_d = drop_q;
      if (in_fire && !addr_ok && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign o_drop_cnt = drop_q;
`endif

   assign o_valid    = out_vld_q;
   assign o_data     = out_q;
   assign o_valid_pe = req_vld_q;
   assign o_data_pe  = req_q;

endmodule

// File: doc/pe_noc_interface.md
Name: pe_noc_interface

Overview:
- Network interface at every non-scheduler switch; it is the responder end of the scheduler-to-NoC packet protocol.
- Accepts request flits {data, pck_no, y, x} from the local switch port. It strips the header, hands the payload to the local PE and remembers pck_no.
- Each PE result is re-tagged with the matching pck_no and addressed to the scheduler's switch, then returned to the NoC so the scheduler's reorder memory can place it by pck_no.

Parameters:
- DATA_W, 32, payload width.
- X_W, 2, x-coordinate field width.
- Y_W, 2, y-coordinate field width.
- PCK_W, 4, packet-number (tag) field width.
- TAG_DEPTH, 4, outstanding request tags held; power of 2, at least 2.
- MY_X, 0, this switch's x coordinate.
- MY_Y, 1, this switch's y coordinate.
- SCH_X, 0, scheduler switch x coordinate.
- SCH_Y, 0, scheduler switch y coordinate.
- TOTAL_W = DATA_W+PCK_W+Y_W+X_W (derived).
- Flit layout, LSB first: x [X_W-1:0], y [X_W+Y_W-1:X_W], pck_no [X_W+Y_W+PCK_W-1:X_W+Y_W], data [TOTAL_W-1:X_W+Y_W+PCK_W].

Ports:
- clk, input, 1, sole clock; rising edge.
- reset, input, 1, synchronous, active-high.
- i_valid, input, 1, NoC-to-NI flit valid.
- i_data, input, TOTAL_W, NoC-to-NI flit.
- o_ready, output, 1, NI can accept a flit.
- o_valid, output, 1, NI-to-NoC flit valid.
- o_data, output, TOTAL_W, NI-to-NoC flit.
- i_ready, input, 1, NoC accepts the flit.
- o_valid_pe, output, 1, request payload valid to PE.
- o_data_pe, output, DATA_W, request payload.
- i_ready_pe, input, 1, PE takes the payload.
- i_valid_pe, input, 1, PE result valid.
- i_data_pe, input, DATA_W, PE result.
- o_ready_pe, output, 1, NI accepts the result.
- o_drop_cnt, output, 8, misrouted-flit count; present only with PE_ADDR_CHECK_EN.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous, active-high.
  - During reset: o_valid, o_valid_pe = 0; o_data, o_data_pe = 0; tag FIFO empty; o_drop_cnt = 0.
  - Reset mid-operation discards the held request, held result and all tags; the PE must be reset concurrently.
- Handshakes: a transfer happens on a rising edge where valid and ready are both 1. Once valid is raised, it and its data stay stable until the transfer completes.
- Ingress:
  - o_ready = !req_vld && !tag_full, decoded from registers only; no combinational path from i_ready_pe.
  - On accept: req_reg <= data field, req_vld <= 1, push pck_no into the tag FIFO.
  - o_valid_pe = req_vld; o_data_pe = req_reg.
  - On o_valid_pe && i_ready_pe: req_vld <= 0.
  - Latency: flit accepted at edge N gives o_valid_pe = 1 after edge N. Peak ingress rate is 1 flit per 2 cycles.
- Egress:
  - o_ready_pe = tag_nonempty && (!o_valid || i_ready).
  - On accept: o_data <= {i_data_pe, tag_head, SCH_Y, SCH_X}, o_valid <= 1, pop the tag.
  - On o_valid && i_ready with no new load: o_valid <= 0. With a new load in the same cycle, o_valid stays 1 (back-to-back, 1 result per cycle).
  - Latency: result accepted at edge M gives o_valid = 1 after edge M.
- Ordering: the PE returns results in request order, and tags are matched in FIFO order.
- Tag FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - Push never occurs while full, because o_ready already includes the tag_full term, even when a pop occurs that cycle.
  - Pointers wrap modulo TAG_DEPTH; the count is log2(TAG_DEPTH)+1 bits.
- A PE result with no outstanding tag is stalled (o_ready_pe = 0) until one exists.
- The header x/y of incoming flits is ignored unless PE_ADDR_CHECK_EN is defined.

Optional Feature:
- Macro: PE_ADDR_CHECK_EN.
- Defined:
  - A flit whose x != MY_X or y != MY_Y is still accepted (o_ready unchanged) but discarded: no req_reg load and no tag push.
  - o_drop_cnt increments by 1 per discarded flit and saturates at 255.
- Undefined: no address comparison; every flit is delivered to the PE; the o_drop_cnt port and counter are absent.

Decomposition:
- Package noc_pkg: X_W, Y_W, PCK_W, DATA_W defaults, TOTAL_W, field LSB/MSB offset constants, SCH_X/SCH_Y defaults, and a flit pack/unpack function pair.
- Sub-module tag_fifo (PCK_W wide, TAG_DEPTH deep synchronous FIFO with full/empty/count). Everything else stays in pe_noc_interface.

Test Plan:
- Reset: hold reset 3 cycles while driving i_valid=1 and i_valid_pe=1 -> o_valid=0, o_valid_pe=0, o_ready_pe=0; o_ready=1 in the first cycle after reset.
- Round trip: flit data=0xCAFE0001, pck_no=5, y=1, x=0; PE echoes data+1 -> o_valid_pe one cycle after accept; o_data = {0xCAFE0002, 5, 0, 0}.
- Tag full: 4 requests pck_no 1..4, PE holds results -> o_ready=0 after the 4th is taken by the PE. Then 4 results are released -> tags emerge 1,2,3,4 in order, and o_ready=1 again.
- Egress backpressure: i_ready=0 for 6 cycles with o_valid=1 -> o_data stable and o_ready_pe=0. Then i_ready=1 with the PE streaming -> one result per cycle.
- Spurious result: i_valid_pe=1 with no outstanding tag -> o_ready_pe=0 and no o_valid until a request flit arrives.
- PE_ADDR_CHECK_EN with MY=(0,1): flit addressed (1,1) -> o_ready=1, o_valid_pe stays 0, o_drop_cnt=1. After 300 misrouted flits -> o_drop_cnt=255.
